// File: rtl/wb_stage.sv
// wb_stage -- writeback end of the register-file interface.
//
// Holds the MEM/WB pipeline register. From it, the block selects the write
// data and extends load data. It drives the register-file write port, and
// the same values feed the forwarding logic. Each retired instruction
// commits exactly once, even under hold, flush or a misaligned load.
//
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit wb_instret
// retire counter output.
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   mem_valid .. mem_rdata       instruction fields arriving from MEM
//   hold                         freeze the WB register
//   flush                        kill the instruction entering WB
//   wb_valid, wb_pc              WB register occupancy and PC
//   wb_rd_addr, wb_wdata,
//   wb_reg_write                 register-file write port
//   wb_commit                    one-cycle retire pulse
//   wb_misalign                  one-cycle misaligned-load pulse
//   wb_instret                   retired-instruction count (optional)
module wb_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_reg_write,
    input  logic [2:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_imm32,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            hold,
    input  logic            flush,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_wdata,
    output logic            wb_reg_write,
    output logic            wb_commit,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     wb_instret,
`endif
    output logic            wb_misalign
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            reg_write;
        logic [2:0]      sel;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rdata;
    } wb_reg_t;

    wb_reg_t r;
    logic    committed;  // the instruction in WB has already retired or flagged

    // Pipeline register: flush > hold > load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid  <= 1'b0;
            committed <= 1'b0;
            r         <= '{pc: RESET_PC, default: '0};
        end else if (flush) begin
            wb_valid  <= 1'b0;
            committed <= 1'b0;
        end else if (hold) begin
            // The first WB cycle has already produced its commit or misalign
            // pulse, so every later held cycle stays silent.
            committed <= committed | wb_valid;
        end else begin
            wb_valid  <= mem_valid;
            committed <= 1'b0;
            r         <= '{pc:        mem_pc,
                           rd:        mem_rd_addr,
                           reg_write: mem_reg_write,
                           sel:       mem_wb_sel,
                           funct3:    mem_funct3,
                           alu:       mem_alu_result,
                           imm:       mem_imm32,
                           rdata:     mem_rdata};
        end
    end

    // Load extension.
    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic            is_load;
    logic            misaligned;

    assign off     = r.alu[1:0];
    assign is_load = (r.sel == 3'd1);

    always_comb begin
        ld_byte = r.rdata[7:0];
        case (off)
            2'd0: ld_byte = r.rdata[7:0];
            2'd1: ld_byte = r.rdata[15:8];
            2'd2: ld_byte = r.rdata[23:16];
            2'd3: ld_byte = r.rdata[31:24];
            default: ld_byte = r.rdata[7:0];
        endcase
        ld_half = off[1] ? r.rdata[31:16] : r.rdata[15:0];

        ld_data = r.rdata;
        case (r.funct3)
            3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101: ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = r.rdata;
        endcase

        misaligned = 1'b0;
        if (is_load) begin
            if ((r.funct3 == 3'b001 || r.funct3 == 3'b101) && off[0])
                misaligned = 1'b1;
            else if (r.funct3 == 3'b010 && off != 2'd0)
                misaligned = 1'b1;
        end
    end

    // Write-data select; sel values 5-7 are reserved and fall back to ALU.
    always_comb begin
        case (r.sel)
            3'd1:    wb_wdata = ld_data;
            3'd2:    wb_wdata = r.pc + XLEN'(4);
            3'd3:    wb_wdata = r.imm;
            3'd4:    wb_wdata = r.pc + r.imm;
            default: wb_wdata = r.alu;
        endcase
    end

    assign wb_pc        = r.pc;
    assign wb_rd_addr   = r.rd;
    assign wb_commit    = wb_valid & ~committed & ~misaligned;
    assign wb_misalign  = wb_valid & ~committed & misaligned;
    // x0 writes still retire but never reach the register file.
    assign wb_reg_write = wb_commit & r.reg_write & (r.rd != 5'd0);

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wb_instret <= 64'd0;
        else if (wb_commit)
            wb_instret <= wb_instret + 64'd1;
    end
`endif

endmodule
